// File: rtl/sum_datapath.sv
//----------------------------------------------------------------------------
//  Module      : sum_datapath
//  Description : Datapath for the summation unit. Computes
//                S = N + (N-1) + ... + 1 under control of the 2-bit
//                summation FSM ({m1,m0}). It returns the zero-detect flag
//                nill to that FSM, captures the final sum on entry to DONE
//                and pulses done for one cycle.
//                Optional feature macro: SUMDP_OVERFLOW_EN
//                  defined   -> sticky overflow output is present
//                  undefined -> accumulator wraps silently, no overflow port
//  Revision    : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module sum_datapath #(
  parameter int WIDTH     = 8,
  parameter int SUM_WIDTH = 2 * WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 m0,
  input  logic                 m1,
  input  logic [WIDTH-1:0]     din,
  output logic                 nill,
  output logic                 busy,
  output logic [SUM_WIDTH-1:0] acc,
  output logic [SUM_WIDTH-1:0] result,
  output logic                 done
`ifdef SUMDP_OVERFLOW_EN
  ,
  output logic                 overflow
`endif
);

  // Control codes issued by the summation FSM, encoded as {m1,m0}.
  localparam logic [1:0] C_CTRL_LOAD = 2'b00;
  localparam logic [1:0] C_CTRL_TEST = 2'b01;
  localparam logic [1:0] C_CTRL_ACC  = 2'b10;
  localparam logic [1:0] C_CTRL_DONE = 2'b11;

  localparam logic [WIDTH-1:0] C_N_ONE = WIDTH'(1);

  logic [1:0]           w_ctrl;
  logic                 w_n_zero;
  logic [SUM_WIDTH-1:0] w_n_ext;
  logic [SUM_WIDTH-1:0] w_acc_sum;

  logic [WIDTH-1:0]     n_q,         n_d;
  logic [SUM_WIDTH-1:0] s_q,         s_d;
  logic [SUM_WIDTH-1:0] result_q,    result_d;
  logic                 done_q,      done_d;
  logic [1:0]           prev_ctrl_q;

  assign w_ctrl   = {m1, m0};
  assign w_n_zero = (n_q == {WIDTH{1'b0}});

  // Counter is zero-extended to the accumulator width before the add.
  generate
    if (SUM_WIDTH > WIDTH) begin : g_ext_pad
      assign w_n_ext = {{(SUM_WIDTH - WIDTH){1'b0}}, n_q};
    end else begin : g_ext_same
      assign w_n_ext = n_q[SUM_WIDTH-1:0];
    end
  endgenerate

`ifdef SUMDP_OVERFLOW_EN
  // One extra bit keeps the carry-out so the sticky flag can observe it.
  logic [SUM_WIDTH:0] w_sum_wide;
  logic               w_carry;
  logic               overflow_q;

  assign w_sum_wide = {1'b0, s_q} + {1'b0, w_n_ext};
  assign w_acc_sum  = w_sum_wide[SUM_WIDTH-1:0];
  assign w_carry    = w_sum_wide[SUM_WIDTH];
`else
  // Carry beyond SUM_WIDTH is simply dropped.
  assign w_acc_sum  = s_q + w_n_ext;
`endif

  // Next-state decode of the counter, accumulator and done capture.
  always_comb begin
    n_d      = n_q;
    s_d      = s_q;
    result_d = result_q;
    done_d   = 1'b0;

    case (w_ctrl)
      C_CTRL_LOAD: begin
        n_d = din;
        s_d = {SUM_WIDTH{1'b0}};
      end
      C_CTRL_ACC: begin
        // An ACC with N already zero is an FSM protocol slip; hold rather
        // than let the counter wrap to all-ones.
        if (!w_n_zero) begin
          s_d = w_acc_sum;
          n_d = n_q - C_N_ONE;
        end
      end
      C_CTRL_TEST,
      C_CTRL_DONE: begin
        n_d = n_q;
        s_d = s_q;
      end
      default: begin
        n_d = n_q;
        s_d = s_q;
      end
    endcase

    // Only the first cycle of a DONE run captures and pulses.
    if ((w_ctrl == C_CTRL_DONE) && (prev_ctrl_q != C_CTRL_DONE)) begin
      result_d = s_q;
      done_d   = 1'b1;
    end
  end

  // Datapath registers; reset overrides every control code.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_q         <= {WIDTH{1'b0}};
      s_q         <= {SUM_WIDTH{1'b0}};
      result_q    <= {SUM_WIDTH{1'b0}};
      done_q      <= 1'b0;
      prev_ctrl_q <= C_CTRL_LOAD;
    end else begin
      n_q         <= n_d;
      s_q         <= s_d;
      result_q    <= result_d;
      done_q      <= done_d;
      prev_ctrl_q <= w_ctrl;
    end
  end

`ifdef SUMDP_OVERFLOW_EN
  // Sticky overflow: set by any carrying ACC, cleared only by reset or LOAD.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (w_ctrl == C_CTRL_LOAD) begin
      overflow_q <= 1'b0;
    end else if ((w_ctrl == C_CTRL_ACC) && !w_n_zero && w_carry) begin
      overflow_q <= 1'b1;
    end
  end

  assign overflow = overflow_q;
`endif

  assign nill   = w_n_zero;
  assign busy   = m1 ^ m0;
  assign acc    = s_q;
  assign result = result_q;
  assign done   = done_q;

endmodule

`default_nettype wire

// File: tb/tb_sum_datapath.sv
//----------------------------------------------------------------------------
//  Module      : tb_sum_datapath
//  Description : Directed self-checking bench for sum_datapath. A 16-bit
//                accumulator instance and an 8-bit (wrapping) instance share
//                all stimulus. Honours SUMDP_OVERFLOW_EN when defined.
//  Revision    : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_sum_datapath;

  localparam logic [1:0] C_LOAD = 2'b00;
  localparam logic [1:0] C_TEST = 2'b01;
  localparam logic [1:0] C_ACC  = 2'b10;
  localparam logic [1:0] C_DONE = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0, m1;
  logic [7:0]  din;

  logic        nill, busy, done;
  logic [15:0] acc, result;
  logic        nill8, busy8, done8;
  logic [7:0]  acc8, result8;
`ifdef SUMDP_OVERFLOW_EN
  logic        ovf, ovf8;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  sum_datapath #(.WIDTH(8), .SUM_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .m0(m0), .m1(m1), .din(din),
    .nill(nill), .busy(busy), .acc(acc), .result(result), .done(done)
`ifdef SUMDP_OVERFLOW_EN
    , .overflow(ovf)
`endif
  );

  sum_datapath #(.WIDTH(8), .SUM_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .m0(m0), .m1(m1), .din(din),
    .nill(nill8), .busy(busy8), .acc(acc8), .result(result8), .done(done8)
`ifdef SUMDP_OVERFLOW_EN
    , .overflow(ovf8)
`endif
  );

  // Apply a control code, let one rising edge pass, sample 1 time unit later.
  task automatic cyc(input logic [1:0] c);
    {m1, m0} = c;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; din = 8'd4; {m1, m0} = C_LOAD;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_total++; if (nill !== 1'b1) $display("FAIL reset_nill got=%b exp=1", nill); else n_pass++;
    n_total++; if (acc !== 16'd0) $display("FAIL reset_acc got=%0d exp=0", acc); else n_pass++;
    n_total++; if (result !== 16'd0 || done !== 1'b0)
      $display("FAIL reset_result_done got=%0d/%b exp=0/0", result, done); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
  endtask

  task automatic test_sum4();
    logic [15:0] exp_acc [4];
    exp_acc[0] = 16'd4; exp_acc[1] = 16'd7; exp_acc[2] = 16'd9; exp_acc[3] = 16'd10;
    din = 8'd4;
    cyc(C_LOAD);
    n_total++; if (nill !== 1'b0) $display("FAIL s4_load_nill got=%b exp=0", nill); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      cyc(C_TEST);
      n_total++; if (busy !== 1'b1) $display("FAIL s4_busy_test got=%b exp=1", busy); else n_pass++;
      cyc(C_ACC);
      n_total++; if (acc !== exp_acc[i])
        $display("FAIL s4_acc[%0d] got=%0d exp=%0d", i, acc, exp_acc[i]); else n_pass++;
    end
    cyc(C_TEST);
    n_total++; if (nill !== 1'b1) $display("FAIL s4_final_nill got=%b exp=1", nill); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL s4_done_early got=%b exp=0", done); else n_pass++;
    cyc(C_DONE);
    n_total++; if (done !== 1'b1 || result !== 16'd10)
      $display("FAIL s4_done got=%b/%0d exp=1/10", done, result); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL s4_busy_done got=%b exp=0", busy); else n_pass++;
    din = 8'd0;
    cyc(C_LOAD);
    n_total++; if (done !== 1'b0) $display("FAIL s4_done_width got=%b exp=0", done); else n_pass++;
  endtask

  task automatic test_zero();
    din = 8'd0;
    cyc(C_LOAD);
    cyc(C_TEST);
    n_total++; if (nill !== 1'b1) $display("FAIL z_nill got=%b exp=1", nill); else n_pass++;
    cyc(C_DONE);
    n_total++; if (done !== 1'b1 || result !== 16'd0 || acc !== 16'd0)
      $display("FAIL z_done got=%b/%0d/%0d exp=1/0/0", done, result, acc); else n_pass++;
  endtask

  task automatic test_max();
    int bad_nill = 0;
    din = 8'd255;
    cyc(C_LOAD);
    for (int k = 1; k <= 255; k++) begin
      cyc(C_TEST);
      cyc(C_ACC);
      if (nill !== ((k == 255) ? 1'b1 : 1'b0)) bad_nill++;
    end
    n_total++; if (bad_nill != 0) $display("FAIL max_nill got=%0d_bad exp=0_bad", bad_nill); else n_pass++;
    cyc(C_TEST);
    cyc(C_DONE);
    n_total++; if (result !== 16'd32640) $display("FAIL max_result got=%0d exp=32640", result); else n_pass++;
    n_total++; if (result8 !== 8'd128) $display("FAIL max_result8 got=%0d exp=128", result8); else n_pass++;
`ifdef SUMDP_OVERFLOW_EN
    n_total++; if (ovf !== 1'b0 || ovf8 !== 1'b1)
      $display("FAIL max_ovf got=%b/%b exp=0/1", ovf, ovf8); else n_pass++;
`endif
  endtask

  task automatic test_wrap();
    din = 8'd30;
    cyc(C_LOAD);
`ifdef SUMDP_OVERFLOW_EN
    n_total++; if (ovf8 !== 1'b0) $display("FAIL wrap_load_clr got=%b exp=0", ovf8); else n_pass++;
`endif
    for (int k = 1; k <= 30; k++) begin
      cyc(C_TEST);
      cyc(C_ACC);
`ifdef SUMDP_OVERFLOW_EN
      if (k == 10 || k == 11) begin
        n_total++; if (ovf8 !== (k == 11))
          $display("FAIL wrap_ovf_at_acc%0d got=%b exp=%b", k, ovf8, (k == 11)); else n_pass++;
      end
`endif
    end
    cyc(C_TEST);
    cyc(C_DONE);
    n_total++; if (result8 !== 8'd209) $display("FAIL wrap_result8 got=%0d exp=209", result8); else n_pass++;
    n_total++; if (result !== 16'd465) $display("FAIL wrap_result16 got=%0d exp=465", result); else n_pass++;
    cyc(C_LOAD);
`ifdef SUMDP_OVERFLOW_EN
    n_total++; if (ovf8 !== 1'b0) $display("FAIL wrap_ovf_clear got=%b exp=0", ovf8); else n_pass++;
`endif
  endtask

  task automatic test_midrun_reset();
    din = 8'd6;
    cyc(C_LOAD);
    cyc(C_TEST); cyc(C_ACC);
    cyc(C_TEST); cyc(C_ACC);
    cyc(C_TEST);
    rst = 1'b1;
    cyc(C_ACC);
    rst = 1'b0;
    n_total++; if (acc !== 16'd0 || nill !== 1'b1)
      $display("FAIL rst_mid_state got=%0d/%b exp=0/1", acc, nill); else n_pass++;
    n_total++; if (result !== 16'd0 || done !== 1'b0)
      $display("FAIL rst_mid_out got=%0d/%b exp=0/0", result, done); else n_pass++;
    din = 8'd3;
    cyc(C_LOAD);
    for (int k = 0; k < 3; k++) begin
      cyc(C_TEST);
      cyc(C_ACC);
    end
    cyc(C_TEST);
    cyc(C_DONE);
    n_total++; if (result !== 16'd6 || done !== 1'b1)
      $display("FAIL rst_rerun got=%0d/%b exp=6/1", result, done); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int extra = 0;
    din = 8'd2;
    cyc(C_LOAD);
    cyc(C_TEST); cyc(C_ACC);
    cyc(C_TEST); cyc(C_ACC);
    cyc(C_TEST);
    cyc(C_DONE);
    n_total++; if (done !== 1'b1 || result !== 16'd3)
      $display("FAIL b2b_first got=%b/%0d exp=1/3", done, result); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      cyc(C_DONE);
      if (done !== 1'b0) extra++;
    end
    n_total++; if (extra != 0) $display("FAIL b2b_hold_pulses got=%0d exp=0", extra); else n_pass++;
    cyc(C_LOAD);
    n_total++; if (done !== 1'b0 || acc !== 16'd0)
      $display("FAIL b2b_reload got=%b/%0d exp=0/0", done, acc); else n_pass++;
    cyc(C_DONE);
    n_total++; if (done !== 1'b1 || result !== 16'd0)
      $display("FAIL b2b_second got=%b/%0d exp=1/0", done, result); else n_pass++;
    // Drive an ACC while N is already zero.
    din = 8'd1;
    cyc(C_LOAD);
    cyc(C_TEST);
    cyc(C_ACC);
    cyc(C_ACC);
    n_total++; if (acc !== 16'd1 || nill !== 1'b1)
      $display("FAIL forced_acc got=%0d/%b exp=1/1", acc, nill); else n_pass++;
    cyc(C_ACC);
    n_total++; if (acc !== 16'd1 || nill !== 1'b1)
      $display("FAIL forced_acc2 got=%0d/%b exp=1/1", acc, nill); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; m0 = 1'b0; m1 = 1'b0; din = 8'd0;
    test_reset();
    test_sum4();
    test_zero();
    test_max();
    test_wrap();
    test_midrun_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
